conv3_issue_ctrl: RTL and testbench
===================================

Name: conv3_issue_ctrl

Overview:
Transmit-side controller for the 3x3 convolution pre-processing stage. Fetches one 9-tap weight set per (output channel, input channel) pair from the weight buffer. Presents that set with conv3_weight_valid, then issues one conv3_ifm_weight_hs per IFM tile beat, holding the weights stable across the whole channel. Sits between the weight BRAM / IFM line-buffer and the registered pre-processing stage in front of the conv3 PE array.

Parameters:
DW, 16, fixed-point data width per tap
K2, 9, taps per kernel (3x3)
CH_W, 10, width of channel counts
TILE_W, 12, width of tile-per-channel count
ADDR_W, 12, weight buffer address width
RD_LAT, 1, weight buffer read latency in cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; config is sampled when start=1 in IDLE
cfg_in_ch  in  CH_W  input channel count
cfg_out_ch  in  CH_W  output channel count
cfg_tiles  in  TILE_W  IFM tile beats per input channel
cfg_wbase  in  ADDR_W  first weight-set address
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at job end
wbuf_rd_en  out  1  weight buffer read strobe
wbuf_rd_addr  out  ADDR_W  weight-set address
wbuf_rd_data  in  DW*K2  packed 9 taps, tap0 in LSBs, valid RD_LAT cycles after rd_en
ifm_tile_valid  in  1  IFM line buffer has a tile beat
ifm_tile_ready  out  1  IFM tile beat consumed this cycle
accum_ready  in  1  downstream accumulator can accept a beat
conv3_weight_valid  out  1  weight bus holds a new set
conv3_ifm_weight_hs  out  1  tile beat + weights issued to the PE path
weight_data_out  out  DW*K2  packed weight set
last_in_ch  out  1  qualifies hs beats of the final input channel of the current output channel

Behaviour:
- Reset: all outputs 0. FSM returns to IDLE and counters clear. A reset during any state aborts the job with no done pulse.
- FSM: IDLE -> FETCH -> WAIT -> PRESENT -> STREAM -> (FETCH | DONE) -> IDLE.
- IDLE: start=1 latches the config and sets busy.
  - If any of cfg_in_ch, cfg_out_ch or cfg_tiles is 0, go to DONE (no reads, no hs).
  - start in any other state is ignored.
- FETCH (1 cycle): wbuf_rd_en=1, wbuf_rd_addr=current address.
- WAIT (RD_LAT cycles): on the last cycle, wbuf_rd_data is captured into weight_data_out.
- PRESENT (1 cycle): conv3_weight_valid=1, hs=0. These must never be asserted in the same cycle.
- STREAM: hs = ifm_tile_ready = ifm_tile_valid & accum_ready. Tile counter increments per hs.
  - conv3_weight_valid=0 throughout.
  - weight_data_out holds constant from PRESENT until the cycle after the last hs of the channel.
- Last beat (tile_cnt==cfg_tiles-1 & hs):
  - If not the final pair, advance in_ch and go to FETCH. On in_ch wrap, advance out_ch.
  - If it is the final pair, go to DONE.
- Address: starts at cfg_wbase and increments by 1 per fetch, modulo 2^ADDR_W (wraps silently).
- last_in_ch = (in_ch_cnt==cfg_in_ch-1) while in STREAM.
- DONE (1 cycle): done=1, busy drops the same cycle. Next state is IDLE.
- Latency with RD_LAT=1 and start at cycle 0:
  - rd_en at cycle 1.
  - weight_valid at cycle 3.
  - First hs possible at cycle 4.
  - Minimum gap between channels: 3 cycles with no hs.
- Backpressure: if ifm_tile_valid=1 and accum_ready=0, hs and ready stay 0. There is no internal tile buffering.
- Total hs count per job = in_ch*out_ch*tiles. Counters are sized so that the maximum configuration does not overflow.

Decomposition:
- Shared package: FSM state encoding, DW and K2 constants, weight-bus pack/unpack helpers (tap index to bit slice).
- One natural sub-module: conv3_loop_cnt, the nested tile/in_ch/out_ch counter with last flags. The FSM and weight register stay in the top module.

Test Plan:
1. Reset then start with in_ch=1, out_ch=1, tiles=4, wbase=0x010, ifm_tile_valid=1, accum_ready=1 -> rd_addr=0x010 at cycle 1; weight_valid at cycle 3; hs at cycles 4-7 with last_in_ch=1; done at cycle 8.
2. in_ch=2, out_ch=2, tiles=3, wbase=0x000 -> read addresses 0,1,2,3 in order; 12 hs total; last_in_ch high only on beats of ic=1; weight_valid never coincides with hs.
3. tiles=5 with accum_ready toggling 1,0,0,1,... -> hs only on accum_ready=1 cycles; weight_data_out unchanged throughout the channel; exactly 5 hs.
4. wbase=0xFFF, in_ch=2, out_ch=1 -> second fetch addresses 0x000 (wrap); job completes normally.
5. cfg_tiles=0 (also repeat with cfg_in_ch=0) -> no rd_en, no hs; done one cycle after the DONE transition; busy low afterwards.
6. Assert rst mid-STREAM, then issue a second start during busy -> all outputs go to 0 the cycle after reset with no done pulse; a start issued while busy is ignored.

Source files
------------

// File: rtl/conv3_issue_ctrl_pkg.sv
// Shared constants, FSM encoding and weight-bus tap helpers for the conv3 issue controller.
package conv3_issue_ctrl_pkg;
  localparam int DW     = 16;
  localparam int K2     = 9;
  localparam int CH_W   = 10;
  localparam int TILE_W = 12;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 1;
  localparam int WSET_W = DW * K2;
  localparam int WCNT_W = $clog2(RD_LAT + 1);

  typedef logic [WSET_W-1:0] wset_t;
  typedef logic [DW-1:0]     tap_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_STREAM, S_DONE
  } state_t;

  function automatic tap_t get_tap(input wset_t w, input int unsigned idx);
    return w[idx*DW +: DW];
  endfunction

  function automatic wset_t set_tap(input wset_t w, input int unsigned idx, input tap_t t);
    wset_t r;
    r = w;
    r[idx*DW +: DW] = t;
    return r;
  endfunction
endpackage

// File: rtl/conv3_issue_ctrl_if.sv
// Job config/status, weight buffer read port and IFM/PE handshake bundle.
interface conv3_issue_ctrl_if;
  import conv3_issue_ctrl_pkg::*;

  logic              start;
  logic [CH_W-1:0]   cfg_in_ch;
  logic [CH_W-1:0]   cfg_out_ch;
  logic [TILE_W-1:0] cfg_tiles;
  logic [ADDR_W-1:0] cfg_wbase;
  logic              busy;
  logic              done;
  logic              wbuf_rd_en;
  logic [ADDR_W-1:0] wbuf_rd_addr;
  wset_t             wbuf_rd_data;
  logic              ifm_tile_valid;
  logic              ifm_tile_ready;
  logic              accum_ready;
  logic              conv3_weight_valid;
  logic              conv3_ifm_weight_hs;
  wset_t             weight_data_out;
  logic              last_in_ch;

  modport master (
    input  start, cfg_in_ch, cfg_out_ch, cfg_tiles, cfg_wbase,
    input  wbuf_rd_data, ifm_tile_valid, accum_ready,
    output busy, done, wbuf_rd_en, wbuf_rd_addr, ifm_tile_ready,
    output conv3_weight_valid, conv3_ifm_weight_hs, weight_data_out, last_in_ch
  );

  modport slave (
    output start, cfg_in_ch, cfg_out_ch, cfg_tiles, cfg_wbase,
    output wbuf_rd_data, ifm_tile_valid, accum_ready,
    input  busy, done, wbuf_rd_en, wbuf_rd_addr, ifm_tile_ready,
    input  conv3_weight_valid, conv3_ifm_weight_hs, weight_data_out, last_in_ch
  );
endinterface

// File: rtl/conv3_loop_cnt.sv
// Nested tile / input-channel / output-channel counter with terminal flags for one job.
module conv3_loop_cnt
  import conv3_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [CH_W-1:0]   out_ch,
  input  logic [TILE_W-1:0] tiles,
  output logic              tile_last,
  output logic              in_last,
  output logic              out_last
);
  logic [TILE_W-1:0] tile_cnt;
  logic [CH_W-1:0]   in_cnt;
  logic [CH_W-1:0]   out_cnt;

  assign tile_last = (tile_cnt == tiles - TILE_W'(1));
  assign in_last   = (in_cnt == in_ch - CH_W'(1));
  assign out_last  = (out_cnt == out_ch - CH_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tile_cnt <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else if (step) begin
      if (tile_last) begin
        tile_cnt <= '0;
        if (in_last) begin
          in_cnt  <= '0;
          out_cnt <= out_last ? '0 : out_cnt + CH_W'(1);
        end else begin
          in_cnt <= in_cnt + CH_W'(1);
        end
      end else begin
        tile_cnt <= tile_cnt + TILE_W'(1);
      end
    end
  end
endmodule

// File: rtl/conv3_issue_ctrl.sv
// Fetches one 9-tap weight set per (out_ch, in_ch) pair and issues it with each IFM tile beat.
// state | meaning: IDLE wait start; FETCH read strobe; WAIT read latency; PRESENT weight_valid;
//       STREAM tile beats; DONE one-cycle done pulse
module conv3_issue_ctrl
  import conv3_issue_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  conv3_issue_ctrl_if.master bus
);
  state_t            state_q, state_d;
  logic [CH_W-1:0]   in_ch_q, out_ch_q;
  logic [TILE_W-1:0] tiles_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WCNT_W-1:0] wait_cnt;
  wset_t             weight_q;
  logic              accept, cfg_zero, hs, wait_tc;
  logic              tile_last, in_last, out_last;

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign cfg_zero = (bus.cfg_in_ch == '0) || (bus.cfg_out_ch == '0) || (bus.cfg_tiles == '0);
  assign hs       = (state_q == S_STREAM) && bus.ifm_tile_valid && bus.accum_ready;
  assign wait_tc  = (wait_cnt == '0);

  conv3_loop_cnt u_loop (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .step      (hs),
    .in_ch     (in_ch_q),
    .out_ch    (out_ch_q),
    .tiles     (tiles_q),
    .tile_last (tile_last),
    .in_last   (in_last),
    .out_last  (out_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = cfg_zero ? S_DONE : S_FETCH;
      S_FETCH:   state_d = S_WAIT;
      S_WAIT:    if (wait_tc) state_d = S_PRESENT;
      S_PRESENT: state_d = S_STREAM;
      S_STREAM:  if (hs && tile_last) state_d = (in_last && out_last) ? S_DONE : S_FETCH;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy                = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done                = (state_q == S_DONE);
    bus.wbuf_rd_en          = (state_q == S_FETCH);
    bus.conv3_weight_valid  = (state_q == S_PRESENT);
    bus.conv3_ifm_weight_hs = hs;
    bus.ifm_tile_ready      = hs;
    bus.last_in_ch          = (state_q == S_STREAM) && in_last;
  end

  assign bus.wbuf_rd_addr    = addr_q;
  assign bus.weight_data_out = weight_q;

  // Address advances after each fetch so the next pair reads the next set; wraps at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ch_q  <= '0;
      out_ch_q <= '0;
      tiles_q  <= '0;
      addr_q   <= '0;
      wait_cnt <= '0;
      weight_q <= '0;
    end else begin
      if (accept) begin
        in_ch_q  <= bus.cfg_in_ch;
        out_ch_q <= bus.cfg_out_ch;
        tiles_q  <= bus.cfg_tiles;
        addr_q   <= bus.cfg_wbase;
      end
      if (state_q == S_FETCH) begin
        addr_q   <= addr_q + ADDR_W'(1);
        wait_cnt <= WCNT_W'(RD_LAT - 1);
      end else if (state_q == S_WAIT && !wait_tc) begin
        wait_cnt <= wait_cnt - WCNT_W'(1);
      end
      if (state_q == S_WAIT && wait_tc) weight_q <= bus.wbuf_rd_data;
    end
  end
endmodule

// File: tb/tb_conv3_issue_ctrl.sv
// Scoreboard bench: a job-level reference model queues expected reads, weight sets and beats;
// a negedge monitor pops and compares whenever the controller presents them.
module tb_conv3_issue_ctrl;
  import conv3_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3_issue_ctrl_if bus_if ();
  conv3_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct packed {
    wset_t w;
    logic  last_in;
    logic  last_tile;
  } beat_t;

  wset_t             mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] exp_rd [$];
  wset_t             exp_wv [$];
  beat_t             exp_hs [$];
  int                exp_done = 0;
  int                errors = 0;
  int                checks = 0;
  int                cyc = 0, t0 = 0, rel;
  int                first_rd, wv_rel, hs_first, hs_last, hs_n, done_rel, rd_n;
  logic              done_seen = 1'b0;
  logic              holding = 1'b0;
  wset_t             hold_w;
  beat_t             mb;

  task automatic check_i(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_w(input string name, input wset_t got, input wset_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=event exp=none", name);
  endtask

  // Weight buffer with one cycle of read latency.
  always @(posedge clk) if (bus_if.wbuf_rd_en) bus_if.wbuf_rd_data <= mem[bus_if.wbuf_rd_addr];

  // Job model: each (oc, ic) pair reads the next address and streams 'tiles' beats of that set.
  task automatic push_model(input int ic, input int oc, input int tl, input int wb);
    exp_done++;
    if (ic == 0 || oc == 0 || tl == 0) return;
    for (int o = 0; o < oc; o++) begin
      for (int i = 0; i < ic; i++) begin
        logic [ADDR_W-1:0] a;
        a = ADDR_W'((wb + o*ic + i) % (1 << ADDR_W));
        exp_rd.push_back(a);
        exp_wv.push_back(mem[a]);
        for (int t = 0; t < tl; t++)
          exp_hs.push_back('{w: mem[a], last_in: (i == ic-1), last_tile: (t == tl-1)});
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus_if.start && !bus_if.busy && !bus_if.done) t0 = cyc;
      rel = cyc - t0;
      if (bus_if.wbuf_rd_en) begin
        rd_n++;
        if (first_rd < 0) first_rd = rel;
        if (exp_rd.size() == 0) fail_event("unexpected_rd");
        else check_i("rd_addr", int'(bus_if.wbuf_rd_addr), int'(exp_rd.pop_front()));
      end
      if (holding) check_w("weight_hold", bus_if.weight_data_out, hold_w);
      if (bus_if.conv3_weight_valid) begin
        if (wv_rel < 0) wv_rel = rel;
        check_i("wv_hs_overlap", int'(bus_if.conv3_ifm_weight_hs), 0);
        if (exp_wv.size() == 0) fail_event("unexpected_wv");
        else check_w("wv_data", bus_if.weight_data_out, exp_wv.pop_front());
        hold_w  = bus_if.weight_data_out;
        holding = 1'b1;
      end
      if (bus_if.conv3_ifm_weight_hs || bus_if.ifm_tile_ready) begin
        check_i("ready_eq_hs", int'(bus_if.ifm_tile_ready), int'(bus_if.conv3_ifm_weight_hs));
        check_i("hs_qualified", int'(bus_if.ifm_tile_valid && bus_if.accum_ready), 1);
      end
      if (bus_if.conv3_ifm_weight_hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = rel;
        hs_last = rel;
        if (exp_hs.size() == 0) fail_event("unexpected_hs");
        else begin
          mb = exp_hs.pop_front();
          check_w("hs_weight", bus_if.weight_data_out, mb.w);
          check_i("last_in_ch", int'(bus_if.last_in_ch), int'(mb.last_in));
          if (mb.last_tile) holding = 1'b0;
        end
      end
      if (bus_if.done) begin
        done_seen = 1'b1;
        done_rel  = rel;
        if (exp_done == 0) fail_event("unexpected_done");
        else begin
          exp_done--;
          check_i("busy_at_done", int'(bus_if.busy), 0);
          check_i("rd_left", exp_rd.size(), 0);
          check_i("wv_left", exp_wv.size(), 0);
          check_i("hs_left", exp_hs.size(), 0);
        end
      end
    end
  end

  task automatic set_inputs(input int mode, input int k);
    case (mode)
      0: begin bus_if.ifm_tile_valid = 1'b1; bus_if.accum_ready = 1'b1; end
      1: begin bus_if.ifm_tile_valid = 1'b1; bus_if.accum_ready = (k % 3 == 0); end
      default: begin
        bus_if.ifm_tile_valid = ($urandom_range(3) != 0);
        bus_if.accum_ready    = ($urandom_range(2) != 0);
      end
    endcase
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_job(input int ic, input int oc, input int tl, input int wb,
                         input int mode, input logic inject);
    first_rd = -1; wv_rel = -1; hs_first = -1; hs_last = -1; done_rel = -1;
    hs_n = 0; rd_n = 0; done_seen = 1'b0;
    bus_if.cfg_in_ch  = CH_W'(ic);
    bus_if.cfg_out_ch = CH_W'(oc);
    bus_if.cfg_tiles  = TILE_W'(tl);
    bus_if.cfg_wbase  = ADDR_W'(wb);
    bus_if.start      = 1'b1;
    set_inputs(mode, 0);
    push_model(ic, oc, tl, wb);
    for (int k = 1; k < 3000 && !done_seen; k++) begin
      @(posedge clk); #1;
      bus_if.start = inject && (k == 6);
      if (inject && k == 6) begin
        bus_if.cfg_in_ch  = CH_W'(3);
        bus_if.cfg_out_ch = CH_W'(3);
        bus_if.cfg_tiles  = TILE_W'(2);
        bus_if.cfg_wbase  = ADDR_W'(12'h300);
      end
      set_inputs(mode, k);
    end
    if (!done_seen) check_i("job_timeout", 0, 1);
    bus_if.start = 1'b0;
    bus_if.ifm_tile_valid = 1'b0;
    bus_if.accum_ready = 1'b0;
    @(posedge clk); #1;
    check_i("busy_after_job", int'(bus_if.busy), 0);
  endtask

  task automatic check_zero_outputs();
    check_i("rst_busy", int'(bus_if.busy), 0);
    check_i("rst_done", int'(bus_if.done), 0);
    check_i("rst_rd_en", int'(bus_if.wbuf_rd_en), 0);
    check_i("rst_rd_addr", int'(bus_if.wbuf_rd_addr), 0);
    check_i("rst_ready", int'(bus_if.ifm_tile_ready), 0);
    check_i("rst_wv", int'(bus_if.conv3_weight_valid), 0);
    check_i("rst_hs", int'(bus_if.conv3_ifm_weight_hs), 0);
    check_w("rst_wdata", bus_if.weight_data_out, '0);
    check_i("rst_last", int'(bus_if.last_in_ch), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      wset_t w;
      w = '0;
      for (int t = 0; t < K2; t++) w = set_tap(w, t, tap_t'($urandom));
      mem[i] = w;
    end
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.cfg_in_ch = '0; bus_if.cfg_out_ch = '0;
    bus_if.cfg_tiles = '0; bus_if.cfg_wbase = '0;
    bus_if.ifm_tile_valid = 1'b0; bus_if.accum_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs();
    @(posedge clk); #1;

    // Single channel, cycle-exact latency
    run_job(1, 1, 4, 12'h010, 0, 1'b0);
    check_i("t_first_rd", first_rd, 1);
    check_i("t_wv", wv_rel, 3);
    check_i("t_hs_first", hs_first, 4);
    check_i("t_hs_last", hs_last, 7);
    check_i("t_done", done_rel, 8);
    check_i("t_hs_n", hs_n, 4);

    run_job(2, 2, 3, 12'h000, 0, 1'b0);
    check_i("j2_hs_n", hs_n, 12);
    check_i("j2_rd_n", rd_n, 4);

    run_job(1, 1, 5, 12'h123, 1, 1'b0);
    check_i("bp_hs_n", hs_n, 5);

    run_job(2, 1, 2, 12'hFFF, 2, 1'b0);
    check_i("wrap_rd_n", rd_n, 2);

    run_job(1, 1, 0, 12'h050, 0, 1'b0);
    check_i("z_tiles_done", done_rel, 1);
    check_i("z_tiles_rd", rd_n, 0);
    check_i("z_tiles_hs", hs_n, 0);
    run_job(0, 3, 3, 12'h050, 0, 1'b0);
    check_i("z_inch_done", done_rel, 1);
    check_i("z_inch_rd", rd_n, 0);
    check_i("z_inch_hs", hs_n, 0);

    // Start while busy must not disturb the running job
    run_job(1, 1, 8, 12'h040, 0, 1'b1);
    check_i("inj_hs_n", hs_n, 8);
    check_i("inj_rd_n", rd_n, 1);

    // Reset in the middle of STREAM aborts with no done
    hs_n = 0; done_seen = 1'b0;
    bus_if.cfg_in_ch = CH_W'(2); bus_if.cfg_out_ch = CH_W'(2);
    bus_if.cfg_tiles = TILE_W'(6); bus_if.cfg_wbase = ADDR_W'(12'h200);
    bus_if.start = 1'b1;
    push_model(2, 2, 6, 12'h200);
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.ifm_tile_valid = 1'b1; bus_if.accum_ready = 1'b1;
    for (int k = 0; k < 50 && hs_n < 2; k++) begin @(posedge clk); #1; end
    check_i("abort_in_stream", int'(hs_n >= 2), 1);
    rst = 1'b1; bus_if.ifm_tile_valid = 1'b0; bus_if.accum_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd.delete(); exp_wv.delete(); exp_hs.delete();
    exp_done = 0; holding = 1'b0;
    @(negedge clk);
    check_zero_outputs();
    repeat (20) @(posedge clk);
    #1 check_i("no_done_after_rst", int'(done_seen), 0);

    for (int j = 0; j < 6; j++)
      run_job($urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(5, 1),
              $urandom_range((1 << ADDR_W) - 1), 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
